// File: rtl/sprite_pkg.sv
// Shared sprite definitions: default ROM geometry and RGB565 pixel layout.
package sprite_pkg;

    localparam int unsigned SPRITE_AW = 10;
    localparam int unsigned SPRITE_DW = 16;

    localparam int unsigned RGB565_R_MSB = 15;
    localparam int unsigned RGB565_R_LSB = 11;
    localparam int unsigned RGB565_G_MSB = 10;
    localparam int unsigned RGB565_G_LSB = 5;
    localparam int unsigned RGB565_B_MSB = 4;
    localparam int unsigned RGB565_B_LSB = 0;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: one-hot pick of the first requester at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick
);

    logic [N-1:0] rot;
    logic [N-1:0] first;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot   = N'({req, req} >> ptr);
        first = rot & (~rot + N'(1));
        pick  = N'(({first, first} << ptr) >> N);
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Arbitrates sprite ROM reads: requester 0 has fixed priority during active video,
// everyone else shares round-robin; a tag pipeline routes returned data.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = SPRITE_AW,
    parameter int unsigned DW   = SPRITE_DW,
    parameter int unsigned LAT  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 active_video,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   addr,
    output logic [NREQ-1:0]      gnt,
    output logic [AW-1:0]        rom_addr,
    input  logic [DW-1:0]        rom_readdata,
    output logic [DW-1:0]        rdata,
    output logic [NREQ-1:0]      rvalid
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef struct packed {
        logic          vld;
        logic [IW-1:0] idx;
    } tag_t;

    logic [NREQ-1:0] rr_pick_w;
    logic            fixed_w;
    logic [IW-1:0]   gnt_idx;
    logic [AW-1:0]   sel_addr;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    tag_t [LAT-1:0]  tag_q, tag_d;

    rr_pick #(
        .N  (NREQ),
        .PW (IW)
    ) u_rr_pick (
        .req  (req),
        .ptr  (rr_ptr_q),
        .pick (rr_pick_w)
    );

    // Grant is held off entirely while reset is asserted.
    always_comb begin
        fixed_w = active_video & req[0];
        gnt     = '0;
        if (!reset) begin
            gnt = fixed_w ? NREQ'(1) : rr_pick_w;
        end
    end

    always_comb begin
        gnt_idx  = '0;
        sel_addr = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_idx  = IW'(i);
                sel_addr = addr[i*AW +: AW];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if ((|gnt) && !fixed_w) begin
            rr_ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
        end

        rom_addr   = (|gnt) ? sel_addr : rom_addr_q;
        rom_addr_d = rom_addr;

        tag_d        = tag_q;
        tag_d[0].vld = |gnt;
        tag_d[0].idx = gnt_idx;
        for (int unsigned k = 1; k < LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end

        rvalid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rvalid[i] = tag_q[LAT-1].vld && (tag_q[LAT-1].idx == IW'(i));
        end

        // ROM data passes straight through on the return cycle and is held otherwise.
        rdata   = (|rvalid) ? rom_readdata : rdata_q;
        rdata_d = rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            rom_addr_q <= '0;
            rdata_q    <= '0;
            tag_q      <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rom_addr_q <= rom_addr_d;
            rdata_q    <= rdata_d;
            tag_q      <= tag_d;
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: LAT=1 instance with a read scoreboard,
// plus a LAT=3 instance sharing the same inputs for the long-latency return check.
module tb_sprite_rom_arbiter;

    logic        clk;
    logic        reset;
    logic        active_video;
    logic [3:0]  req;
    logic [39:0] addr;
    logic [3:0]  gnt, rvalid, gnt3, rvalid3;
    logic [9:0]  rom_addr, rom_addr3;
    logic [15:0] rom_readdata, rdata, rom_readdata3, rdata3;
    logic [15:0] rom_p1;
    logic [15:0] rom_p3 [3];

    logic [9:0] a_of [4];

    typedef struct {
        int          due;
        int          idx;
        logic [15:0] data;
    } sb_t;
    sb_t sb [$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    sprite_rom_arbiter #(.NREQ(4), .AW(10), .DW(16), .LAT(1)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .active_video (active_video),
        .req          (req),
        .addr         (addr),
        .gnt          (gnt),
        .rom_addr     (rom_addr),
        .rom_readdata (rom_readdata),
        .rdata        (rdata),
        .rvalid       (rvalid)
    );

    sprite_rom_arbiter #(.NREQ(4), .AW(10), .DW(16), .LAT(3)) u_dut3 (
        .clk          (clk),
        .reset        (reset),
        .active_video (active_video),
        .req          (req),
        .addr         (addr),
        .gnt          (gnt3),
        .rom_addr     (rom_addr3),
        .rom_readdata (rom_readdata3),
        .rdata        (rdata3),
        .rvalid       (rvalid3)
    );

    function automatic logic [15:0] rom_fn(input logic [9:0] a);
        if (a == 10'h155) return 16'hF800;
        return {a[5:0], a} ^ 16'h5A5A;
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ROMs with one- and three-cycle read latency.
    always @(posedge clk) begin
        rom_p1    <= rom_fn(rom_addr);
        rom_p3[0] <= rom_fn(rom_addr3);
        rom_p3[1] <= rom_p3[0];
        rom_p3[2] <= rom_p3[1];
    end
    assign rom_readdata  = rom_p1;
    assign rom_readdata3 = rom_p3[2];

    // Scoreboard: every non-reset cycle either the head read returns or rvalid is quiet.
    always @(posedge clk) begin
        #2;
        if (!reset) begin
            n_total++;
            if (sb.size() != 0 && sb[0].due == cyc) begin
                if (rvalid !== (4'b0001 << sb[0].idx) || rdata !== sb[0].data)
                    $display("FAIL sb_return cyc=%0d: got rvalid=%b rdata=%h, expected rvalid=%b rdata=%h",
                             cyc, rvalid, rdata, 4'b0001 << sb[0].idx, sb[0].data);
                else
                    n_pass++;
                void'(sb.pop_front());
            end else begin
                if (rvalid !== 4'b0000)
                    $display("FAIL sb_quiet cyc=%0d: got rvalid=%b, expected 0000", cyc, rvalid);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_read(input int idx);
        sb.push_back('{due: cyc + 1, idx: idx, data: rom_fn(a_of[idx])});
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'b1111; active_video = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next_cycle(); #1;
            n_total++;
            if (gnt !== 4'b0000) $display("FAIL reset_gnt[%0d]: got %b expected 0000", k, gnt);
            else n_pass++;
            n_total++;
            if (rvalid !== 4'b0000) $display("FAIL reset_rvalid[%0d]: got %b expected 0000", k, rvalid);
            else n_pass++;
            n_total++;
            if (rdata !== 16'h0000) $display("FAIL reset_rdata[%0d]: got %h expected 0000", k, rdata);
            else n_pass++;
            n_total++;
            if (rom_addr !== 10'h000) $display("FAIL reset_rom_addr[%0d]: got %h expected 000", k, rom_addr);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            reset = 1'b0; req = 4'b1111; active_video = 1'b0;
            #1;
            n_total++;
            if (gnt !== (4'b0001 << exp_seq[k]))
                $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, 4'b0001 << exp_seq[k]);
            else n_pass++;
            n_total++;
            if (rom_addr !== a_of[exp_seq[k]])
                $display("FAIL rr_rom_addr[%0d]: got %h expected %h", k, rom_addr, a_of[exp_seq[k]]);
            else n_pass++;
            expect_read(exp_seq[k]);
        end
    endtask

    task automatic test_fixed_priority();
        logic [3:0] r_seq [8]  = '{4'b1000, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011};
        logic       av_seq [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int         exp_seq [8] = '{3, 0, 0, 0, 0, 0, 1, 3};
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            req = r_seq[k]; active_video = av_seq[k];
            #1;
            n_total++;
            if (gnt !== (4'b0001 << exp_seq[k]))
                $display("FAIL fixed_gnt[%0d]: got %b expected %b", k, gnt, 4'b0001 << exp_seq[k]);
            else n_pass++;
            expect_read(exp_seq[k]);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] r_seq [3]   = '{4'b0100, 4'b1001, 4'b1001};
        int         exp_seq [3] = '{2, 3, 0};
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            req = r_seq[k]; active_video = 1'b0;
            #1;
            n_total++;
            if (gnt !== (4'b0001 << exp_seq[k]))
                $display("FAIL wrap_gnt[%0d]: got %b expected %b", k, gnt, 4'b0001 << exp_seq[k]);
            else n_pass++;
            expect_read(exp_seq[k]);
        end
    endtask

    task automatic test_idle();
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            req = 4'b0000;
            #1;
            n_total++;
            if (gnt !== 4'b0000) $display("FAIL idle_gnt[%0d]: got %b expected 0000", k, gnt);
            else n_pass++;
            n_total++;
            if (rom_addr !== a_of[0]) $display("FAIL idle_rom_addr[%0d]: got %h expected %h", k, rom_addr, a_of[0]);
            else n_pass++;
            n_total++;
            if (rdata !== rom_fn(a_of[0])) $display("FAIL idle_rdata[%0d]: got %h expected %h", k, rdata, rom_fn(a_of[0]));
            else n_pass++;
        end
    endtask

    task automatic test_data_return();
        next_cycle();
        req = 4'b0100; active_video = 1'b0;
        #1;
        n_total++;
        if (gnt !== 4'b0100 || rom_addr !== 10'h155)
            $display("FAIL data_grant: got gnt=%b rom_addr=%h expected gnt=0100 rom_addr=155", gnt, rom_addr);
        else n_pass++;
        n_total++;
        if (rom_addr3 !== 10'h155) $display("FAIL data_rom_addr3: got %h expected 155", rom_addr3);
        else n_pass++;
        expect_read(2);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            req = 4'b0000;
            #1;
            if (k == 1) begin
                n_total++;
                if (rvalid !== 4'b0100 || rdata !== 16'hF800)
                    $display("FAIL data_lat1: got rvalid=%b rdata=%h expected 0100/F800", rvalid, rdata);
                else n_pass++;
            end else begin
                n_total++;
                if (rdata !== 16'hF800) $display("FAIL data_hold[%0d]: got %h expected F800", k, rdata);
                else n_pass++;
            end
            n_total++;
            if (k < 3 && rvalid3 !== 4'b0000)
                $display("FAIL data_lat3_early[%0d]: got rvalid3=%b expected 0000", k, rvalid3);
            else if (k == 3 && (rvalid3 !== 4'b0100 || rdata3 !== 16'hF800))
                $display("FAIL data_lat3: got rvalid3=%b rdata3=%h expected 0100/F800", rvalid3, rdata3);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic av_seq [5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int   exp_seq [5] = '{3, 0, 0, 0, 1};
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            req = 4'b1111; active_video = av_seq[k];
            #1;
            n_total++;
            if (gnt !== (4'b0001 << exp_seq[k]))
                $display("FAIL b2b_gnt[%0d]: got %b expected %b", k, gnt, 4'b0001 << exp_seq[k]);
            else n_pass++;
            expect_read(exp_seq[k]);
        end
    endtask

    task automatic test_reset_mid_read();
        next_cycle();
        req = 4'b0100; active_video = 1'b0;
        #1;
        n_total++;
        if (gnt !== 4'b0100) $display("FAIL midrst_gnt: got %b expected 0100", gnt);
        else n_pass++;
        next_cycle();
        reset = 1'b1; req = 4'b1111;
        #1;
        n_total++;
        if (gnt !== 4'b0000 || rvalid !== 4'b0000 || rdata !== 16'h0000 || rom_addr !== 10'h000)
            $display("FAIL midrst_outputs: got gnt=%b rvalid=%b rdata=%h rom_addr=%h expected all zero",
                     gnt, rvalid, rdata, rom_addr);
        else n_pass++;
        next_cycle();
        next_cycle();
        reset = 1'b0; req = 4'b1100;
        #1;
        n_total++;
        if (gnt !== 4'b0100) $display("FAIL midrst_restart_gnt: got %b expected 0100", gnt);
        else n_pass++;
        expect_read(2);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            req = 4'b0000;
        end
        #1;
        n_total++;
        if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending reads expected 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; active_video = 1'b0; req = 4'b0000;
        a_of[0] = 10'h0A0; a_of[1] = 10'h1B1; a_of[2] = 10'h155; a_of[3] = 10'h3C3;
        addr = {a_of[3], a_of[2], a_of[1], a_of[0]};
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_wrap();
        test_idle();
        test_data_return();
        test_back_to_back();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
